// File: rtl/sat_solver_pkg.sv
// Shared sizes, literal word type, FSM states and literal helpers for the CNF-SAT solver.
package common;
  localparam int number_literal  = 30;
  localparam int number_variable = number_literal / 2;
  localparam int number_clause   = 128;
  localparam int cnt_w           = $clog2(number_clause + 1);
  localparam int idx_w           = $clog2(number_clause);

  typedef logic [number_literal-1:0]  lit_t;
  typedef logic [number_variable-1:0] asg_t;
  typedef enum logic [1:0] {IDLE, LOAD, SOLVE, DONE} state_t;

  // Expand an assignment into its literal word: even bit = x_k, odd bit = ~x_k.
  function automatic lit_t lit_of(asg_t a);
    lit_t l;
    l = '0;
    for (int k = 0; k < number_variable; k++) begin
      l[2*k]   = a[k];
      l[2*k+1] = ~a[k];
    end
    return l;
  endfunction

  function automatic logic is_taut(lit_t w);
    logic t;
    t = 1'b0;
    for (int k = 0; k < number_variable; k++) t = t | (w[2*k] & w[2*k+1]);
    return t;
  endfunction
endpackage

// File: rtl/sat_solver_if.sv
// Host-side bus of the SAT solver: clause load stream in, search results out.
interface sat_solver_if;
  import common::*;
  logic load;
  lit_t i;
  logic ended;
  logic sat;
  lit_t model;

  modport master(output load, output i, input ended, input sat, input model);
  modport slave (input load, input i, output ended, output sat, output model);
endinterface

// File: rtl/sat_solver_clause_eval.sv
// Combinational check of every stored clause against one literal word.
module clause_eval
  import common::*;
(
  input  logic [number_clause-1:0][number_literal-1:0] mem,
  input  logic [cnt_w-1:0]                             count,
  input  lit_t                                         lit,
  output logic                                         all_sat
);
  logic [number_clause-1:0] ok;

  // Slots at or beyond count hold stale data and are treated as satisfied.
  for (genvar j = 0; j < number_clause; j++) begin : g_cl
    assign ok[j] = (cnt_w'(j) >= count) || (|(mem[j] & lit));
  end

  assign all_sat = &ok;
endmodule

// File: rtl/sat_solver_top.sv
// Exhaustive CNF-SAT solver: streams clauses in, then walks every assignment one per cycle.
// Optional build macro TAUTOLOGY_FILTER_EN drops tautological clauses during load.
module sat_solver_top
  import common::*;
(
  input  logic         clock,
  input  logic         reset,
  sat_solver_if.slave  bus
);
  logic [number_clause-1:0][number_literal-1:0] mem;
  state_t           state;
  logic [cnt_w-1:0] count;
  asg_t             a;
  logic             overflow;
  logic             res_ended;
  logic             res_sat;
  lit_t             res_model;
  lit_t             cur_lit;
  logic             all_sat;
  logic             accept;
  logic             room;
  logic             enter_load;

`ifdef TAUTOLOGY_FILTER_EN
  assign accept = (bus.i != '0) && !is_taut(bus.i);
`else
  assign accept = (bus.i != '0);
`endif

  assign room       = count < cnt_w'(number_clause);
  assign enter_load = bus.load && (state != LOAD);
  assign cur_lit    = lit_of(a);

  clause_eval u_eval (
    .mem    (mem),
    .count  (count),
    .lit    (cur_lit),
    .all_sat(all_sat)
  );

  // Clause storage needs no reset: count alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (state == LOAD && bus.load && accept && room) mem[count[idx_w-1:0]] <= bus.i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      a         <= '0;
      overflow  <= 1'b0;
      res_ended <= 1'b0;
      res_sat   <= 1'b0;
      res_model <= '0;
    end else if (enter_load) begin
      state     <= LOAD;
      count     <= '0;
      a         <= '0;
      overflow  <= 1'b0;
      res_ended <= 1'b0;
      res_sat   <= 1'b0;
      res_model <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.load) begin
            if (accept) begin
              if (room) count    <= count + 1'b1;
              else      overflow <= 1'b1;
            end
          end else begin
            a <= '0;
            if (overflow) begin
              state     <= DONE;
              res_ended <= 1'b1;
              res_sat   <= 1'b0;
              res_model <= '0;
            end else begin
              state <= SOLVE;
            end
          end
        end
        SOLVE: begin
          if (all_sat) begin
            state     <= DONE;
            res_ended <= 1'b1;
            res_sat   <= 1'b1;
            res_model <= cur_lit;
          end else if (a == '1) begin
            state     <= DONE;
            res_ended <= 1'b1;
            res_sat   <= 1'b0;
            res_model <= '0;
          end else begin
            a <= a + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ended = res_ended;
  assign bus.sat   = res_sat;
  assign bus.model = res_model;
endmodule

// File: tb/tb_sat_solver_top.sv
// Scoreboard bench for sat_solver_top: directed CNF problems with hand-computed results.
module tb_sat_solver_top;
  import common::*;

  typedef struct {
    logic sat;
    lit_t model;
    int   start;
    int   lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_ended = 1'b0;
  exp_t exp_q[$];
  lit_t cl[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sat_solver_if bus();

  sat_solver_top dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: each rising ended is matched against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (bus.ended && !prev_ended) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ended: got ended=1 want no result (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sat", 64'(bus.sat), 64'(e.sat));
        chk("model", 64'(bus.model), 64'(e.model));
        chk("latency", 64'(cyc - e.start), 64'(e.lat));
      end
    end
    prev_ended = bus.ended;
  end

  task automatic load_only();
    @(negedge clock);
    bus.load = 1'b1;
    bus.i    = '0;
    foreach (cl[k]) begin
      @(negedge clock);
      bus.i = cl[k];
    end
    @(negedge clock);
    bus.load = 1'b0;
    bus.i    = '0;
  endtask

  task automatic run(input int lat, input logic s, input lit_t m);
    exp_t e;
    int   n;
    load_only();
    e.sat = s; e.model = m; e.start = cyc + 1; e.lat = lat;
    exp_q.push_back(e);
    n = 0;
    while (!bus.ended && n < lat + 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.ended) begin
      total++;
      bad++;
      $display("FAIL timeout: got ended=0 want ended=1 within %0d cycles", lat + 20);
    end else begin
      repeat (3) @(negedge clock);
      chk("hold_ended", 64'(bus.ended), 64'd1);
      chk("hold_model", 64'(bus.model), 64'(m));
    end
  endtask

  initial begin
    bus.load = 1'b0;
    bus.i    = '0;
    repeat (2) @(negedge clock);
    chk("rst_ended", 64'(bus.ended), 64'd0);
    chk("rst_sat",   64'(bus.sat),   64'd0);
    chk("rst_model", 64'(bus.model), 64'd0);
    reset = 1'b1;

    cl = {};                          run(1, 1'b1, 30'h2AAAAAAA);
    cl = {30'h1};                     run(2, 1'b1, 30'h2AAAAAA9);
    cl = {30'h5, 30'h2, 30'h18};      run(7, 1'b1, 30'h2AAAAA96);
    cl = {30'h3};                     run(1, 1'b1, 30'h2AAAAAAA);
    cl = {30'h10000000};              run(16385, 1'b1, 30'h1AAAAAAA);
    cl = {30'h1, 30'h2};              run(32768, 1'b0, 30'h0);

    cl = {};
    for (int k = 0; k < number_clause; k++) cl.push_back(30'h1);
    run(2, 1'b1, 30'h2AAAAAA9);
    cl.push_back(30'h1);
    run(0, 1'b0, 30'h0);

    // Reset while results are held, then while searching.
    cl = {30'h1}; run(2, 1'b1, 30'h2AAAAAA9);
    @(negedge clock); reset = 1'b0; #1;
    chk("rst_done_ended", 64'(bus.ended), 64'd0);
    chk("rst_done_sat",   64'(bus.sat),   64'd0);
    chk("rst_done_model", 64'(bus.model), 64'd0);
    @(negedge clock); reset = 1'b1;
    cl = {30'h1, 30'h2};
    load_only();
    repeat (100) @(negedge clock);
    reset = 1'b0; #1;
    chk("rst_solve_ended", 64'(bus.ended), 64'd0);
    chk("rst_solve_model", 64'(bus.model), 64'd0);
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_ended", 64'(bus.ended), 64'd0);
    cl = {30'h1}; run(2, 1'b1, 30'h2AAAAAA9);

    // Raising load mid-search abandons it and starts a fresh problem.
    cl = {30'h1, 30'h2};
    load_only();
    repeat (50) @(negedge clock);
    cl = {30'h1}; run(2, 1'b1, 30'h2AAAAAA9);

    cl = {30'h1, 30'h3}; run(2, 1'b1, 30'h2AAAAAA9);
    cl = {};
    for (int k = 0; k < number_clause; k++) cl.push_back(30'h1);
    cl.push_back(30'h3);
`ifdef TAUTOLOGY_FILTER_EN
    run(2, 1'b1, 30'h2AAAAAA9);
`else
    run(0, 1'b0, 30'h0);
`endif

    repeat (2) @(negedge clock);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
